// File: rtl/cache_pkg.sv
// cache_pkg
//   Types and constants shared by the L1 data cache and its L2 message queue.
//   - l2_op_t : L2 bus operation carried from the cache to the L2 port
//   - mesi_t  : cache line coherence state
//   - LINE_BYTES_DEF : default cache line size in bytes
package cache_pkg;

  typedef enum logic [1:0] {
    L2_READ   = 2'd0,
    L2_WRITE  = 2'd1,
    L2_RFO    = 2'd2,
    L2_RETURN = 2'd3
  } l2_op_t;

  typedef enum logic [1:0] {
    MESI_INVALID   = 2'd0,
    MESI_SHARED    = 2'd1,
    MESI_EXCLUSIVE = 2'd2,
    MESI_MODIFIED  = 2'd3
  } mesi_t;

  localparam int LINE_BYTES_DEF = 64;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO. Occupancy is kept in its own register rather than being
//   derived from the pointer difference. Pushes while full and pops while empty
//   are ignored. Storage is not reset; callers mask rdata with !empty.
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   push, wdata     : write request and data
//   pop, rdata      : read request and head data (valid while !empty)
//   full, empty     : occupancy flags
//   count           : occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap on plain increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/l1_l2_msg_queue.sv
// l1_l2_msg_queue
//   Buffers L2 bus operations issued by the L1 data cache and drains them to the
//   L2 port in strict FIFO order. Addresses are line aligned on entry. Keeps
//   saturating per-type counts of delivered messages; with MODE=1 each
//   delivered message is printed in simulation.
//   Handshake: a transfer happens on a rising edge where valid && ready. The
//   sender holds valid, type and address stable until that edge. msg_ready is
//   !full (a same-cycle pop does not free a slot for a push).
// Ports
//   clk, rst                      : clock, asynchronous active-high reset
//   msg_valid/msg_type/msg_addr   : message from the cache
//   msg_ready                     : queue can accept
//   l2_valid/l2_type/l2_addr      : head entry towards L2 (zero when empty)
//   l2_ready                      : L2 consumes the head
//   q_count, q_empty              : occupancy
//   cnt_read..cnt_return          : delivered messages per type
module l1_l2_msg_queue
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 32,
  parameter bit MODE       = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     msg_valid,
  input  logic [1:0]               msg_type,
  input  logic [ADDR_W-1:0]        msg_addr,
  output logic                     msg_ready,
  output logic                     l2_valid,
  output logic [1:0]               l2_type,
  output logic [ADDR_W-1:0]        l2_addr,
  input  logic                     l2_ready,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     q_empty,
  output logic [CNT_W-1:0]         cnt_read,
  output logic [CNT_W-1:0]         cnt_write,
  output logic [CNT_W-1:0]         cnt_rfo,
  output logic [CNT_W-1:0]         cnt_return
);

  localparam int EW = 2 + ADDR_W;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_BYTES - 1));

  logic [EW-1:0]    wdata;
  logic [EW-1:0]    head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  l2_op_t           head_type;
  logic [CNT_W-1:0] cnt_q [4];

  assign wdata     = {msg_type, msg_addr & LINE_MASK};
  assign msg_ready = !full;
  assign l2_valid  = !empty;
  assign q_empty   = empty;
  assign push      = msg_valid && msg_ready;
  assign pop       = l2_valid && l2_ready;
  assign head_type = l2_op_t'(head[EW-1 -: 2]);

  // Storage is unreset, so the head is forced to zero whenever it is not valid.
  assign l2_type = l2_valid ? head[EW-1 -: 2]    : 2'd0;
  assign l2_addr = l2_valid ? head[ADDR_W-1:0]   : '0;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (q_count)
  );

  // Counters stop at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (pop && (cnt_q[head_type] != '1)) begin
      cnt_q[head_type] <= cnt_q[head_type] + 1'b1;
    end
  end

  assign cnt_read   = cnt_q[L2_READ];
  assign cnt_write  = cnt_q[L2_WRITE];
  assign cnt_rfo    = cnt_q[L2_RFO];
  assign cnt_return = cnt_q[L2_RETURN];

`ifndef SYNTHESIS
  generate
    if (MODE) begin : g_display
      always_ff @(posedge clk) begin
        if (!rst && pop) begin
          case (head_type)
            L2_READ:   $display("Read from L2 %h", l2_addr);
            L2_WRITE:  $display("Write to L2 %h", l2_addr);
            L2_RFO:    $display("Read for Ownership from L2 %h", l2_addr);
            default:   $display("Return data to L2 %h", l2_addr);
          endcase
        end
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_l1_l2_msg_queue.sv
// Directed bench for l1_l2_msg_queue (DEPTH=8, CNT_W=2 so saturation is reachable).
module tb_l1_l2_msg_queue;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              msg_valid = 1'b0;
  logic [1:0]        msg_type  = 2'd0;
  logic [ADDR_W-1:0] msg_addr  = '0;
  logic              msg_ready;
  logic              l2_valid;
  logic [1:0]        l2_type;
  logic [ADDR_W-1:0] l2_addr;
  logic              l2_ready = 1'b0;
  logic [3:0]        q_count;
  logic              q_empty;
  logic [CNT_W-1:0]  cnt_read, cnt_write, cnt_rfo, cnt_return;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  l1_l2_msg_queue #(
    .ADDR_W(ADDR_W), .LINE_BYTES(64), .DEPTH(DEPTH), .CNT_W(CNT_W), .MODE(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .msg_valid(msg_valid), .msg_type(msg_type), .msg_addr(msg_addr),
    .msg_ready(msg_ready),
    .l2_valid(l2_valid), .l2_type(l2_type), .l2_addr(l2_addr), .l2_ready(l2_ready),
    .q_count(q_count), .q_empty(q_empty),
    .cnt_read(cnt_read), .cnt_write(cnt_write), .cnt_rfo(cnt_rfo), .cnt_return(cnt_return)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    msg_valid = 1'b0;
    l2_ready = 1'b0;
    cycle();
    rst = 1'b0;
    exp_q.delete();
    cycle();
  endtask

  // Expected entry is the line-aligned address (64-byte lines: low 6 bits zero).
  task automatic push_msg(input logic [1:0] t, input logic [31:0] a);
    check("push_ready", msg_ready, 1'b1);
    msg_valid = 1'b1;
    msg_type  = t;
    msg_addr  = a;
    exp_q.push_back({t, a & 32'hFFFF_FFC0});
    cycle();
    msg_valid = 1'b0;
  endtask

  // One pop per iteration; the head is compared against the scoreboard before the edge.
  task automatic drain(input int n);
    logic [33:0] e;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        check("drain_sb_empty", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("head_valid", l2_valid, 1'b1);
        check("head_type", l2_type, e[33:32]);
        check("head_addr", l2_addr, e[31:0]);
      end
      l2_ready = 1'b1;
      cycle();
      l2_ready = 1'b0;
    end
  endtask

  task automatic check_counters(input string tag, input int r, input int w, input int f, input int x);
    check({tag, "_cnt_read"},   cnt_read,   r);
    check({tag, "_cnt_write"},  cnt_write,  w);
    check({tag, "_cnt_rfo"},    cnt_rfo,    f);
    check({tag, "_cnt_return"}, cnt_return, x);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [33:0] e;
    #2;
    // Reset state
    check("rst_count", q_count, 0);
    check("rst_empty", q_empty, 1'b1);
    check("rst_ready", msg_ready, 1'b1);
    check("rst_valid", l2_valid, 1'b0);
    check("rst_type", l2_type, 0);
    check("rst_addr", l2_addr, 0);
    check_counters("rst", 0, 0, 0, 0);
    do_reset();

    // 1. reset mid-stream with 3 entries queued (and one already counted)
    push_msg(2'd0, 32'h0000_0100);
    push_msg(2'd1, 32'h0000_0200);
    push_msg(2'd2, 32'h0000_0300);
    push_msg(2'd3, 32'h0000_0400);
    drain(1);
    check("t1_count3", q_count, 3);
    check("t1_cnt_read_pre", cnt_read, 1);
    rst = 1'b1;
    #1;
    check("t1_async_count", q_count, 0);
    check("t1_async_valid", l2_valid, 1'b0);
    cycle();
    rst = 1'b0;
    exp_q.delete();
    check("t1_count", q_count, 0);
    check("t1_valid", l2_valid, 1'b0);
    check("t1_ready", msg_ready, 1'b1);
    check("t1_empty", q_empty, 1'b1);
    check("t1_addr", l2_addr, 0);
    check_counters("t1", 0, 0, 0, 0);
    cycle();

    // 2. single READ, held while l2_ready is low
    push_msg(2'd0, 32'h1234_5678);
    check("t2_valid", l2_valid, 1'b1);
    check("t2_addr", l2_addr, 32'h1234_5640);
    check("t2_type", l2_type, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t2_hold_addr", l2_addr, 32'h1234_5640);
      check("t2_hold_valid", l2_valid, 1'b1);
    end
    check("t2_cnt_before", cnt_read, 0);
    drain(1);
    check("t2_cnt_read", cnt_read, 1);
    check("t2_empty_after", l2_valid, 1'b0);

    // 3. fill to DEPTH, 9th waits for the first pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_msg(2'(i % 4), 32'h1000 + 32'(i) * 32'h40 + 32'h5);
    check("t3_full_ready", msg_ready, 1'b0);
    check("t3_full_count", q_count, 8);
    msg_valid = 1'b1;
    msg_type  = 2'd2;
    msg_addr  = 32'h0000_9011;
    cycle();
    check("t3_blocked_count", q_count, 8);
    check("t3_blocked_ready", msg_ready, 1'b0);
    // Pop while full: push still blocked at this edge.
    e = exp_q.pop_front();
    check("t3_pop_type", l2_type, e[33:32]);
    check("t3_pop_addr", l2_addr, e[31:0]);
    l2_ready = 1'b1;
    cycle();
    l2_ready = 1'b0;
    check("t3_after_pop_count", q_count, 7);
    check("t3_after_pop_ready", msg_ready, 1'b1);
    exp_q.push_back({2'd2, 32'h0000_9000});
    cycle();
    msg_valid = 1'b0;
    check("t3_ninth_count", q_count, 8);
    drain(8);
    check("t3_drained", q_empty, 1'b1);
    check_counters("t3", 2, 2, 3, 2);

    // 4. simultaneous push RFO / pop WRITE at count 3
    do_reset();
    push_msg(2'd1, 32'h0000_0040);
    push_msg(2'd0, 32'h0000_0080);
    push_msg(2'd0, 32'h0000_00C0);
    e = exp_q.pop_front();
    check("t4_head_type", l2_type, e[33:32]);
    check("t4_head_addr", l2_addr, e[31:0]);
    msg_valid = 1'b1;
    msg_type  = 2'd2;
    msg_addr  = 32'h0000_0100;
    l2_ready  = 1'b1;
    exp_q.push_back({2'd2, 32'h0000_0100});
    cycle();
    msg_valid = 1'b0;
    l2_ready  = 1'b0;
    check("t4_count", q_count, 3);
    check("t4_cnt_write", cnt_write, 1);
    drain(3);
    check_counters("t4", 2, 1, 1, 0);

    // 5. counter saturation, and pop on empty is ignored
    do_reset();
    for (int i = 0; i < 5; i++) push_msg(2'd3, 32'h0000_2000 + 32'(i) * 32'h40);
    drain(3);
    check("t5_cnt_return_3", cnt_return, 3);
    drain(2);
    check_counters("t5", 0, 0, 0, 3);
    l2_ready = 1'b1;
    cycle();
    l2_ready = 1'b0;
    check("t5_empty_pop_count", q_count, 0);
    check("t5_empty_pop_valid", l2_valid, 1'b0);
    check_counters("t5e", 0, 0, 0, 3);

    // 6. victim write before refill read
    do_reset();
    push_msg(2'd1, 32'hA000_0040);
    push_msg(2'd0, 32'hB000_0040);
    drain(2);
    check_counters("t6", 1, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
